// File: rtl/ptp_ts_queue.sv
// PTP timestamp queue: latches RTC at sop, pushes {ts, infor} on event verdict.
// Ports: clk/rst, int_valid/int_sop/rtc_time, ptp_found/ptp_infor, q_* host side.
module ptp_ts_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          int_valid,
  input  logic          int_sop,
  input  logic [63:0]   rtc_time,
  input  logic          ptp_found,
  input  logic [31:0]   ptp_infor,
  input  logic          q_clr,
  input  logic          q_rd_en,
  output logic [95:0]   q_rd_data,
  output logic          q_empty,
  output logic          q_full,
  output logic [AW:0]   q_cnt,
  output logic [15:0]   q_drop_cnt
);

  logic [63:0]   ts_sop_q;
  logic          found_d1_q;
  logic [95:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [15:0]   drop_q, drop_d;

  logic push, pop, wr_acc, drop;

  assign q_empty    = (cnt_q == '0);
  assign q_full     = (cnt_q == (AW+1)'(DEPTH));
  assign q_cnt      = cnt_q;
  assign q_drop_cnt = drop_q;
  assign q_rd_data  = mem_q[rd_ptr_q];

  // Parser holds ptp_found until next sop, so the rising edge is one push.
  assign push   = ptp_found && !found_d1_q;
  assign pop    = q_rd_en && !q_empty;
  assign wr_acc = push && (!q_full || pop);
  assign drop   = push && q_full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    if (q_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      drop_d   = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_acc && !pop) cnt_d = cnt_q + (AW+1)'(1);
      if (!wr_acc && pop) cnt_d = cnt_q - (AW+1)'(1);
      if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_sop_q   <= '0;
      found_d1_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      drop_q     <= '0;
    end else begin
      // Sop in a push cycle: the push samples the pre-update value.
      if (int_valid && int_sop) ts_sop_q <= rtc_time;
      found_d1_q <= ptp_found;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !q_clr) mem_q[wr_ptr_q] <= {ts_sop_q, ptp_infor};
  end

endmodule

// File: tb/tb_ptp_ts_queue.sv
// Directed bench for ptp_ts_queue.
// Drives packets/verdicts, checks queue state and drained contents.
module tb_ptp_ts_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        int_valid = 1'b0;
  logic        int_sop = 1'b0;
  logic [63:0] rtc_time = '0;
  logic        ptp_found = 1'b0;
  logic [31:0] ptp_infor = '0;
  logic        q_clr = 1'b0;
  logic        q_rd_en = 1'b0;
  logic [95:0] q_rd_data;
  logic        q_empty;
  logic        q_full;
  logic [4:0]  q_cnt;
  logic [15:0] q_drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  ptp_ts_queue #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .int_valid(int_valid), .int_sop(int_sop),
    .rtc_time(rtc_time),
    .ptp_found(ptp_found), .ptp_infor(ptp_infor),
    .q_clr(q_clr), .q_rd_en(q_rd_en),
    .q_rd_data(q_rd_data), .q_empty(q_empty),
    .q_full(q_full), .q_cnt(q_cnt),
    .q_drop_cnt(q_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [95:0] got,
                     input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sop cycle, then verdict cycle (push edge, optional pop/clr there)
  task automatic pkt(input logic [63:0] rtc, input logic found,
                     input logic [31:0] infor, input logic pop,
                     input logic clr);
    int_valid = 1'b1;
    int_sop   = 1'b1;
    rtc_time  = rtc;
    ptp_found = 1'b0;
    step();
    int_sop   = 1'b0;
    int_valid = 1'b0;
    ptp_found = found;
    ptp_infor = infor;
    q_rd_en   = pop;
    q_clr     = clr;
    step();
    q_rd_en   = 1'b0;
    q_clr     = 1'b0;
  endtask

  task automatic pop1();
    q_rd_en = 1'b1;
    step();
    q_rd_en = 1'b0;
  endtask

  function automatic logic [95:0] ent(input int i);
    return {32'(i), 32'(i * 16 + 7), 32'(32'hA000 + i)};
  endfunction

  initial begin
    #2;
    chk("rst_empty", 96'(q_empty), 96'd1);
    chk("rst_full",  96'(q_full), 96'd0);
    chk("rst_cnt",   96'(q_cnt), 96'd0);
    chk("rst_drop",  96'(q_drop_cnt), 96'd0);
    #14 rst = 1'b0;
    step();

    // single event
    pkt(64'h00000005_00001234, 1'b1, 32'h1ABC_0042, 1'b0, 1'b0);
    chk("ev_empty", 96'(q_empty), 96'd0);
    chk("ev_cnt",   96'(q_cnt), 96'd1);
    chk("ev_data",  q_rd_data, 96'h00000005_00001234_1ABC0042);
    pop1();
    chk("ev_pop_empty", 96'(q_empty), 96'd1);
    ptp_found = 1'b0;

    // non-event packets
    pkt(64'h1, 1'b0, 32'h0, 1'b0, 1'b0);
    pkt(64'h2, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    chk("nonev_cnt", 96'(q_cnt), 96'd0);

    // held verdict
    pkt(64'h00000009_00000001, 1'b1, 32'h2000_0001, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    chk("held_cnt", 96'(q_cnt), 96'd1);
    chk("held_data", q_rd_data, 96'h00000009_00000001_20000001);
    pop1();
    chk("held_pop_empty", 96'(q_empty), 96'd1);

    // fill and overflow: 18 packets
    for (int i = 0; i < 18; i++)
      pkt(ent(i)[95:32], 1'b1, ent(i)[31:0], 1'b0, 1'b0);
    chk("fill_full", 96'(q_full), 96'd1);
    chk("fill_cnt",  96'(q_cnt), 96'd16);
    chk("fill_drop", 96'(q_drop_cnt), 96'd2);
    chk("fill_head", q_rd_data, ent(0));

    // full with simultaneous push and pop
    pkt(ent(18)[95:32], 1'b1, ent(18)[31:0], 1'b1, 1'b0);
    chk("pp_cnt",  96'(q_cnt), 96'd16);
    chk("pp_full", 96'(q_full), 96'd1);
    chk("pp_drop", 96'(q_drop_cnt), 96'd2);

    // drain: 1..15 then 18
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("drain%0d", i), q_rd_data, ent(i == 16 ? 18 : i));
      pop1();
    end
    chk("drain_empty", 96'(q_empty), 96'd1);
    chk("drain_drop",  96'(q_drop_cnt), 96'd2);

    // clear in same cycle as push
    pkt(64'h30, 1'b1, 32'h3000_0000, 1'b0, 1'b0);
    pkt(64'h31, 1'b1, 32'h3000_0001, 1'b0, 1'b0);
    chk("preclr_cnt", 96'(q_cnt), 96'd2);
    pkt(64'h32, 1'b1, 32'h3000_0002, 1'b0, 1'b1);
    chk("clr_cnt",   96'(q_cnt), 96'd0);
    chk("clr_drop",  96'(q_drop_cnt), 96'd0);
    chk("clr_empty", 96'(q_empty), 96'd1);
    step();
    step();
    chk("clr_norepush", 96'(q_cnt), 96'd0);

    // async reset with 5 entries queued
    for (int i = 0; i < 5; i++)
      pkt(ent(40 + i)[95:32], 1'b1, ent(40 + i)[31:0], 1'b0, 1'b0);
    chk("pre_rst_cnt", 96'(q_cnt), 96'd5);
    #2 rst = 1'b1;
    #1;
    chk("arst_empty", 96'(q_empty), 96'd1);
    chk("arst_cnt",   96'(q_cnt), 96'd0);
    #2 rst = 1'b0;
    step();
    chk("post_rst_cnt",  96'(q_cnt), 96'd1);
    chk("post_rst_data", q_rd_data, {64'd0, ent(44)[31:0]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
